// File: rtl/team_04_spi_flash_reader.sv
// SPI NOR flash reader: issues READ (0x03) + 24-bit address in mode 0 and
// returns the fetched bytes over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start, CS high
// CMD   | shifting command + address out, MSB first
// DATA  | clocking one byte in
// HOLD  | byte presented on rd_data, SCK parked low, CS low
// GUARD | CS high for 2*CLKDIV cycles before done
module team_04_spi_flash_reader #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [23:0] addr,
  input  logic [7:0]  len,
  output logic        busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic        spi_csb,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int CW = (CLKDIV > 1) ? $clog2(2 * CLKDIV) : 1;
  localparam logic [CW-1:0] HALF_LD  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GUARD_LD = CW'(2 * CLKDIV - 1);
  localparam logic [7:0]    CMD_READ = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    HOLD,
    GUARD
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [4:0]    bit_cnt;
  logic [8:0]    remaining;
  logic [30:0]   tx_shift;
  logic [6:0]    rx_shift;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      remaining <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      busy      <= 1'b0;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      spi_csb   <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CMD;
            busy      <= 1'b1;
            spi_csb   <= 1'b0;
            spi_mosi  <= CMD_READ[7];
            tx_shift  <= {CMD_READ[6:0], addr};
            bit_cnt   <= 5'd31;
            div_cnt   <= HALF_LD;
            remaining <= (len == 8'd0) ? 9'd256 : {1'b0, len};
          end
        end
        CMD, DATA: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - CW'(1);
          end else begin
            div_cnt <= HALF_LD;
            spi_sck <= ~spi_sck;
            // SCK falling: MOSI advances and MISO is sampled on this same edge
            if (spi_sck) begin
              if (state == CMD) begin
                if (bit_cnt == 5'd0) begin
                  state    <= DATA;
                  bit_cnt  <= 5'd7;
                  spi_mosi <= 1'b0;
                end else begin
                  bit_cnt  <= bit_cnt - 5'd1;
                  spi_mosi <= tx_shift[30];
                  tx_shift <= {tx_shift[29:0], 1'b0};
                end
              end else begin
                rx_shift <= {rx_shift[5:0], spi_miso};
                if (bit_cnt == 5'd0) begin
                  state    <= HOLD;
                  rd_data  <= {rx_shift, spi_miso};
                  rd_valid <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt - 5'd1;
                end
              end
            end
          end
        end
        HOLD: begin
          if (rd_ready) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - 9'd1;
            if (remaining == 9'd1) begin
              state <= GUARD;
            end else begin
              state   <= DATA;
              bit_cnt <= 5'd7;
              div_cnt <= HALF_LD;
            end
          end
        end
        GUARD: begin
          // first GUARD cycle raises CS, then the guard interval runs
          if (!spi_csb) begin
            spi_csb <= 1'b1;
            div_cnt <= GUARD_LD;
          end else if (div_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            div_cnt <= div_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
